// File: rtl/fetch_bp_pkg.sv
// Shared types and helpers for the predicting fetch stage.
// Counter encodings, bubble constant and BTB geometry helpers.
package fetch_bp_pkg;

    typedef enum logic [1:0] {
        CTR_SNT = 2'b00,
        CTR_WNT = 2'b01,
        CTR_WT  = 2'b10,
        CTR_ST  = 2'b11
    } bpCtr_t;

    localparam logic [31:0] BUBBLE_INSTR = 32'h0;

    function automatic int btbIdxW(int entries);
        return $clog2(entries);
    endfunction

    function automatic int btbTagW(int xlen, int entries);
        return xlen - $clog2(entries) - 2;
    endfunction

    function automatic bpCtr_t ctrStep(bpCtr_t c, logic taken);
        bpCtr_t n;
        n = c;
        unique case (1'b1)
            taken && (c != CTR_ST):   n = bpCtr_t'(c + 2'd1);
            !taken && (c != CTR_SNT): n = bpCtr_t'(c - 2'd1);
            default:                  n = c;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/fetch_bp_btb.sv
// Direct-mapped branch target buffer with 2-bit counters.
// Combinational lookup port, update port written at the clock edge.
module fetch_bp_btb
    import fetch_bp_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:2] lookupPc,
    output logic            lookupTaken,
    output logic [XLEN-1:0] lookupTarget,
    input  logic            updValid,
    input  logic [XLEN-1:2] updPc,
    input  logic            updTaken,
    input  logic [XLEN-1:0] updTarget
);

    localparam int IDX_W = btbIdxW(ENTRIES);
    localparam int TAG_W = btbTagW(XLEN, ENTRIES);

    logic             valid  [ENTRIES];
    bpCtr_t           ctr    [ENTRIES];
    logic [TAG_W-1:0] tagArr [ENTRIES];
    logic [XLEN-1:0]  tgtArr [ENTRIES];

    logic [IDX_W-1:0] lookIdx;
    logic [TAG_W-1:0] lookTag;
    logic [IDX_W-1:0] updIdx;
    logic [TAG_W-1:0] updTag;
    logic             lookHit;
    logic             updHit;

    assign lookIdx = lookupPc[IDX_W+1:2];
    assign lookTag = lookupPc[XLEN-1:IDX_W+2];
    assign updIdx  = updPc[IDX_W+1:2];
    assign updTag  = updPc[XLEN-1:IDX_W+2];

    assign lookHit = valid[lookIdx] && (tagArr[lookIdx] == lookTag);
    assign updHit  = valid[updIdx] && (tagArr[updIdx] == updTag);

    assign lookupTaken  = lookHit && ctr[lookIdx][1];
    assign lookupTarget = tgtArr[lookIdx];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid[i] <= 1'b0;
                ctr[i]   <= CTR_SNT;
            end
        end else if (updValid) begin
            if (updHit) begin
                ctr[updIdx] <= ctrStep(ctr[updIdx], updTaken);
            end else if (updTaken) begin
                valid[updIdx] <= 1'b1;
                ctr[updIdx]   <= CTR_WT;
            end
        end
    end

    // On a hit the stored tag already equals updTag, so one write covers both cases.
    always_ff @(posedge clk) begin
        if (updValid && updTaken) begin
            tagArr[updIdx] <= updTag;
            tgtArr[updIdx] <= updTarget;
        end
    end

endmodule

// File: rtl/fetch_bp_stage.sv
// Fetch stage: PC, BTB-based next-PC prediction and F/D register.
// Define FETCH_BP_STATS_EN to add branch/mispredict statistics ports.
module fetch_bp_stage
    import fetch_bp_pkg::*;
#(
    parameter int              XLEN        = 32,
    parameter int              BTB_ENTRIES = 16,
    parameter logic [XLEN-1:0] RESET_PC    = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall_f,
    input  logic            stall_d,
    input  logic            flush_d,
    input  logic [31:0]     instr_f,
    output logic [XLEN-1:0] pc_f,
    output logic [31:0]     instr_d,
    output logic [XLEN-1:0] pc_d,
    output logic [XLEN-1:0] pc_plus4_d,
    output logic            valid_d,
    output logic            pred_taken_d,
    output logic [XLEN-1:0] pred_target_d,
    input  logic            res_valid_e,
    input  logic [XLEN-1:0] res_pc_e,
    input  logic            res_taken_e,
    input  logic [XLEN-1:0] res_target_e,
    input  logic            pred_taken_e,
    input  logic [XLEN-1:0] pred_target_e,
    output logic            mispredict_e
`ifdef FETCH_BP_STATS_EN
    ,
    output logic [31:0]     stat_branches,
    output logic [31:0]     stat_mispredicts
`endif
);

    localparam logic [XLEN-1:0] FOUR = XLEN'(4);

    logic            predTaken;
    logic [XLEN-1:0] btbTarget;
    logic [XLEN-1:0] pcPlus4;
    logic [XLEN-1:0] predNext;
    logic [XLEN-1:0] redirectPc;

    fetch_bp_btb #(
        .XLEN    (XLEN),
        .ENTRIES (BTB_ENTRIES)
    ) uBtb (
        .clk          (clk),
        .reset        (reset),
        .lookupPc     (pc_f[XLEN-1:2]),
        .lookupTaken  (predTaken),
        .lookupTarget (btbTarget),
        .updValid     (res_valid_e),
        .updPc        (res_pc_e[XLEN-1:2]),
        .updTaken     (res_taken_e),
        .updTarget    (res_target_e)
    );

    assign pcPlus4  = pc_f + FOUR;
    assign predNext = predTaken ? btbTarget : pcPlus4;

    assign mispredict_e = res_valid_e &&
        ((res_taken_e != pred_taken_e) ||
         (res_taken_e && (res_target_e != pred_target_e)));

    assign redirectPc = res_taken_e ? res_target_e : res_pc_e + FOUR;

    // A redirect wins over stall_f so the wrong path is never held.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_f <= RESET_PC;
        end else if (mispredict_e) begin
            pc_f <= redirectPc;
        end else if (!stall_f) begin
            pc_f <= predNext;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_d       <= BUBBLE_INSTR;
            pc_d          <= '0;
            pc_plus4_d    <= '0;
            valid_d       <= 1'b0;
            pred_taken_d  <= 1'b0;
            pred_target_d <= '0;
        end else if (flush_d || mispredict_e) begin
            instr_d       <= BUBBLE_INSTR;
            pc_d          <= '0;
            pc_plus4_d    <= '0;
            valid_d       <= 1'b0;
            pred_taken_d  <= 1'b0;
            pred_target_d <= '0;
        end else if (!stall_d) begin
            instr_d       <= instr_f;
            pc_d          <= pc_f;
            pc_plus4_d    <= pcPlus4;
            valid_d       <= 1'b1;
            pred_taken_d  <= predTaken;
            pred_target_d <= predNext;
        end
    end

`ifdef FETCH_BP_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else begin
            if (res_valid_e && (stat_branches != '1)) begin
                stat_branches <= stat_branches + 32'd1;
            end
            if (mispredict_e && (stat_mispredicts != '1)) begin
                stat_mispredicts <= stat_mispredicts + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_bp_stage.sv
// Scoreboard bench for fetch_bp_stage (RESET_PC = 0x100, 16-entry BTB).
// Expected values come from a small behavioural model plus directed constants.
module tb_fetch_bp_stage;

    localparam logic [31:0] RPC  = 32'h100;
    localparam logic [31:0] IKEY = 32'hA5A5_0013;

    logic        clk;
    logic        reset;
    logic        stall_f;
    logic        stall_d;
    logic        flush_d;
    logic [31:0] instr_f;
    logic [31:0] pc_f;
    logic [31:0] instr_d;
    logic [31:0] pc_d;
    logic [31:0] pc_plus4_d;
    logic        valid_d;
    logic        pred_taken_d;
    logic [31:0] pred_target_d;
    logic        res_valid_e;
    logic [31:0] res_pc_e;
    logic        res_taken_e;
    logic [31:0] res_target_e;
    logic        pred_taken_e;
    logic [31:0] pred_target_e;
    logic        mispredict_e;
`ifdef FETCH_BP_STATS_EN
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;
`endif

    fetch_bp_stage #(
        .XLEN        (32),
        .BTB_ENTRIES (16),
        .RESET_PC    (RPC)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .stall_f       (stall_f),
        .stall_d       (stall_d),
        .flush_d       (flush_d),
        .instr_f       (instr_f),
        .pc_f          (pc_f),
        .instr_d       (instr_d),
        .pc_d          (pc_d),
        .pc_plus4_d    (pc_plus4_d),
        .valid_d       (valid_d),
        .pred_taken_d  (pred_taken_d),
        .pred_target_d (pred_target_d),
        .res_valid_e   (res_valid_e),
        .res_pc_e      (res_pc_e),
        .res_taken_e   (res_taken_e),
        .res_target_e  (res_target_e),
        .pred_taken_e  (pred_taken_e),
        .pred_target_e (pred_target_e),
        .mispredict_e  (mispredict_e)
`ifdef FETCH_BP_STATS_EN
        ,
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts)
`endif
    );

    assign instr_f = pc_f ^ IKEY;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vecCount = 0;
    int missCount = 0;

    string       expTag [$];
    logic [31:0] expVal [$];

    logic        mValid [16];
    logic [25:0] mTag   [16];
    logic [31:0] mTgt   [16];
    logic [1:0]  mCtr   [16];
    logic [31:0] mPc, mInstrD, mPcD, mPc4D, mPredTgtD;
    logic        mValidD, mPredTD;
    logic [31:0] mBr, mMis;

    task automatic checkVal(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        vecCount++;
        if (got !== exp) begin
            missCount++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] probe(input string tag);
        case (tag)
            "pc_f":          return pc_f;
            "instr_d":       return instr_d;
            "pc_d":          return pc_d;
            "pc_plus4_d":    return pc_plus4_d;
            "valid_d":       return {31'd0, valid_d};
            "pred_taken_d":  return {31'd0, pred_taken_d};
            "pred_target_d": return pred_target_d;
            "mispredict_e":  return {31'd0, mispredict_e};
`ifdef FETCH_BP_STATS_EN
            "stat_branches":    return stat_branches;
            "stat_mispredicts": return stat_mispredicts;
`endif
            default:         return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic expectVal(input string tag, input logic [31:0] v);
        expTag.push_back(tag);
        expVal.push_back(v);
    endtask

    task automatic drain();
        string       t;
        logic [31:0] v;
        while (expTag.size() > 0) begin
            t = expTag.pop_front();
            v = expVal.pop_front();
            checkVal(t, probe(t), v);
        end
    endtask

    task automatic modelReset();
        mPc = RPC;
        mInstrD = 0; mPcD = 0; mPc4D = 0; mPredTgtD = 0;
        mValidD = 0; mPredTD = 0;
        mBr = 0; mMis = 0;
        for (int i = 0; i < 16; i++) begin
            mValid[i] = 0;
            mCtr[i] = 2'b00;
        end
    endtask

    task automatic driveIdle();
        stall_f = 0; stall_d = 0; flush_d = 0;
        res_valid_e = 0; res_pc_e = 0; res_taken_e = 0; res_target_e = 0;
        pred_taken_e = 0; pred_target_e = 0;
    endtask

    task automatic step(input logic sF, input logic sD, input logic fD,
                        input logic rV, input logic [31:0] rPc,
                        input logic rT, input logic [31:0] rTgt,
                        input logic pT, input logic [31:0] pTgt);
        logic        mis, hit, predT, uHit;
        logic [3:0]  li, ui;
        logic [31:0] nxt;
        stall_f = sF; stall_d = sD; flush_d = fD;
        res_valid_e = rV; res_pc_e = rPc; res_taken_e = rT;
        res_target_e = rTgt; pred_taken_e = pT; pred_target_e = pTgt;
        #1;
        mis = rV && ((rT != pT) || (rT && (rTgt != pTgt)));
        expectVal("mispredict_e", {31'd0, mis});
        drain();
        li = mPc[5:2];
        hit = mValid[li] && (mTag[li] == mPc[31:6]);
        predT = hit && mCtr[li][1];
        nxt = predT ? mTgt[li] : mPc + 32'd4;
        if (fD || mis) begin
            mInstrD = 0; mPcD = 0; mPc4D = 0;
            mValidD = 0; mPredTD = 0; mPredTgtD = 0;
        end else if (!sD) begin
            mInstrD = mPc ^ IKEY; mPcD = mPc; mPc4D = mPc + 32'd4;
            mValidD = 1; mPredTD = predT; mPredTgtD = nxt;
        end
        if (mis) mPc = rT ? rTgt : rPc + 32'd4;
        else if (!sF) mPc = nxt;
        if (rV) begin
            ui = rPc[5:2];
            uHit = mValid[ui] && (mTag[ui] == rPc[31:6]);
            if (uHit) begin
                if (rT && mCtr[ui] != 2'b11) mCtr[ui] = mCtr[ui] + 2'd1;
                if (!rT && mCtr[ui] != 2'b00) mCtr[ui] = mCtr[ui] - 2'd1;
                if (rT) mTgt[ui] = rTgt;
            end else if (rT) begin
                mValid[ui] = 1; mTag[ui] = rPc[31:6];
                mTgt[ui] = rTgt; mCtr[ui] = 2'b10;
            end
            mBr = mBr + 1;
        end
        if (mis) mMis = mMis + 1;
        expectVal("pc_f", mPc);
        expectVal("valid_d", {31'd0, mValidD});
        expectVal("instr_d", mInstrD);
        expectVal("pc_d", mPcD);
        expectVal("pc_plus4_d", mPc4D);
        expectVal("pred_taken_d", {31'd0, mPredTD});
        if (mPredTD) expectVal("pred_target_d", mPredTgtD);
        @(posedge clk);
        @(negedge clk);
        driveIdle();
        drain();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic resolve(input logic [31:0] rPc, input logic rT,
                           input logic [31:0] rTgt, input logic pT,
                           input logic [31:0] pTgt);
        step(0, 0, 0, 1, rPc, rT, rTgt, pT, pTgt);
    endtask

    // Not-taken resolve of a branch predicted taken: a cheap way to jump to pc+4.
    task automatic goTo(input logic [31:0] pc);
        resolve(pc - 32'd4, 0, 0, 1, pc);
    endtask

    initial begin
        reset = 1;
        driveIdle();
        modelReset();
        @(negedge clk);
        @(negedge clk);
        reset = 0;
        #1;
        expectVal("pc_f", 32'h100);
        expectVal("valid_d", 0);
        expectVal("instr_d", 0);
        expectVal("mispredict_e", 0);
        drain();

        idle(3);
        expectVal("pc_f", 32'h10C);
        expectVal("pc_d", 32'h108);
        drain();

        resolve(32'h20, 1, 32'h10, 0, 0);
        expectVal("pc_f", 32'h10);
        expectVal("valid_d", 0);
        drain();
        idle(5);
        expectVal("pc_f", 32'h10);
        expectVal("pc_d", 32'h20);
        expectVal("pred_taken_d", 1);
        expectVal("pred_target_d", 32'h10);
        drain();
        resolve(32'h20, 1, 32'h10, 1, 32'h10);
        resolve(32'h20, 1, 32'h10, 1, 32'h10);

        resolve(32'h20, 0, 0, 1, 32'h10);
        expectVal("pc_f", 32'h24);
        drain();
        goTo(32'h20);
        idle(1);
        expectVal("pc_f", 32'h10);
        drain();

        resolve(32'h20, 1, 32'h40, 1, 32'h10);
        expectVal("pc_f", 32'h40);
        drain();
        goTo(32'h20);
        idle(1);
        expectVal("pc_f", 32'h40);
        drain();

        step(1, 1, 0, 1, 32'h1C, 0, 0, 1, 32'h20);
        expectVal("pc_f", 32'h20);
        expectVal("valid_d", 0);
        drain();
        idle(1);
        step(1, 1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0, 0, 0);
        expectVal("pc_f", 32'h40);
        expectVal("pc_d", 32'h20);
        drain();
        step(0, 0, 1, 0, 0, 0, 0, 0, 0);
        expectVal("pc_f", 32'h44);
        expectVal("valid_d", 0);
        drain();

        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0) resolve(32'h20, 1, 32'h80, 0, 0);
            else            resolve(32'h60, 1, 32'h90, 0, 0);
        end
        goTo(32'h60);
        idle(1);
        expectVal("pc_f", 32'h90);
        drain();
        goTo(32'h20);
        idle(1);
        expectVal("pc_f", 32'h24);
        drain();

        resolve(32'hFFFF_FFF8, 1, 32'hFFFF_FFFC, 0, 0);
        idle(1);
        expectVal("pc_f", 32'h0);
        expectVal("pc_plus4_d", 32'h0);
        drain();
        resolve(32'hFFFF_FFFC, 0, 0, 1, 32'h10);
        expectVal("pc_f", 32'h0);
        drain();

`ifdef FETCH_BP_STATS_EN
        expectVal("stat_branches", mBr);
        expectVal("stat_mispredicts", mMis);
        drain();
`endif

        idle(2);
        #2;
        reset = 1;
        #1;
        expectVal("pc_f", 32'h100);
        expectVal("valid_d", 0);
        expectVal("pc_d", 0);
        drain();
        @(negedge clk);
        reset = 0;
        modelReset();
        goTo(32'h20);
        idle(1);
        expectVal("pc_f", 32'h24);
        drain();
`ifdef FETCH_BP_STATS_EN
        expectVal("stat_branches", 32'd1);
        drain();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
